ej32_mem_arb: RTL
=================

# ej32_mem_arb

Byte-memory arbiter sharing the single-port 8-bit memory bus between the eJ32 core (load/store/fetch) and a host port used for dictionary/TIB loading and OBUF/dictionary dumps. The core gets priority. The host gets a guaranteed slot after a bounded wait, plus locked bursts for row dumps. The block sits between the core's bus master and the memory, replacing the direct core-to-memory connection.

## Interface
- ASZ, 17, byte address width (matches core IU address)
- MAX_WAIT, 8, max consecutive cycles a pending host request is refused before a forced host slot (1..255)
- BURST, 16, max host beats per locked burst (1..255)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  core access request
- cpu_we  in  1  core write
- cpu_a  in  ASZ  core address
- cpu_wd  in  8  core write data
- cpu_stall  out  1  core refused this cycle; core holds request and freezes
- cpu_rvalid  out  1  core read data valid (one cycle after grant)
- cpu_rd  out  8  core read data
- hst_req  in  1  host access request
- hst_we  in  1  host write
- hst_lock  in  1  request burst; sampled on the first granted host beat
- hst_a  in  ASZ  host address
- hst_wd  in  8  host write data
- hst_gnt  out  1  host access issued this cycle
- hst_ack  out  1  host access complete; read data valid (one cycle after grant)
- hst_rd  out  8  host read data
- mem_cs  out  1  memory select
- mem_we  out  1  memory write
- mem_a  out  ASZ  memory address
- mem_wd  out  8  memory write data
- mem_rd  in  8  memory read data, valid one cycle after mem_cs

## Operation
- At most one memory access per cycle.
- mem_* are combinational from the selected requester.
- mem_cs = cpu_req&&!cpu_stall || hst_gnt.
- States: S_CPU (default) and S_BST (host burst owns bus).
- S_CPU, normal grant: core granted if cpu_req, unless forced.
- S_CPU, forced host: host granted when hst_req && (!cpu_req || wcnt==MAX_WAIT).
- S_CPU, wait counter wcnt: increments on each cycle hst_req is high and the host is refused. Clears on host grant or when hst_req is low. Saturates at MAX_WAIT.
- S_CPU, burst entry: host granted with hst_lock=1 and BURST>1 -> S_BST, bcnt=1.
- S_BST: host granted whenever hst_req=1; core stalled on any cpu_req. Each grant increments bcnt.
- S_BST exit to S_CPU on any of: hst_lock=0, hst_req=0, or a grant with bcnt==BURST-1. Exit takes effect at that clock edge, so the core is granted the following cycle.
- Read-return tagging: a 1-bit register captures the owner of each issued access.
  - Next cycle, core read -> cpu_rvalid=1, cpu_rd=mem_rd.
  - Next cycle, host read or write -> hst_ack=1, hst_rd=mem_rd (hst_rd is don't-care for writes).
- Core writes produce no rvalid.
- Core-request stability: the core holds cpu_* stable while cpu_stall=1.
- Host-request stability: the host holds hst_* stable until hst_gnt.

## Timing
- Grant, stall and mem_* are same-cycle combinational. Read/ack latency is exactly 1 cycle.
- Back-to-back grants to alternating owners are allowed. Return tagging is per cycle.
- Simultaneous cpu_req/hst_req with wcnt<MAX_WAIT -> core wins. Forced slot lasts exactly one cycle unless hst_lock opens a burst.
- Worst-case core stall = BURST cycles. Worst-case host wait = MAX_WAIT+1 cycles.
- Reset values, all 0: state=S_CPU, wcnt, bcnt, owner tag, cpu_rvalid, hst_ack, cpu_rd, hst_rd.
- While rst=1, these are held 0: mem_cs, hst_gnt, cpu_stall.
- Reset mid-burst: burst abandoned; no ack for an access issued in the reset cycle.

## Configuration
- EJ32_ARB_STATS_EN defined adds three 16-bit saturating counters, cleared by rst:
  - st_cpu: core grants
  - st_hst: host grants
  - st_stl: cpu_stall cycles
- The counters are exposed as output ports st_cpu, st_hst, st_stl.
- Without the macro, the ports and the counter logic are absent; arbitration is identical either way.

## Structure
- ej32_pkg gains:
  - arb_st_t enum {S_CPU, S_BST}
  - arb_own_t enum {OWN_CPU, OWN_HST}
- Sub-module ej32_arb_cnt holds wcnt and bcnt with saturate/clear/compare, parameterized by limit. It is instantiated twice.
- The FSM, grant mux and return tagging live in ej32_mem_arb.

## Test plan
- Core only: read 0x1000 holding 0x3A -> cpu_stall=0, mem_cs same cycle, next cycle cpu_rvalid=1, cpu_rd=0x3A. Write 0x1400 <- 0x55 -> no rvalid, memory holds 0x55.
- Host only: write 0x20 bytes at 0x1000, read them back -> one hst_gnt per cycle, hst_ack 1 cycle later, data matches.
- Contention, MAX_WAIT=8: cpu_req and hst_req both held high -> host granted on cycle 9 only; core stalled exactly that cycle; wcnt back to 0.
- Burst, BURST=16: hst_lock=1 reading 0x1400..0x1410 with cpu_req high -> 16 consecutive hst_gnt, cpu_stall=1 for 16 cycles, core granted on cycle 17.
- Alternating grants: host read then core read on adjacent cycles -> hst_ack, then cpu_rvalid, each with its own byte; no cross-delivery.
- Reset mid-burst at beat 5 -> all outputs 0, state S_CPU; after release a pending cpu_req is granted first cycle.

Source files
------------

// File: rtl/ej32_pkg.sv
// ej32_pkg: shared types for the eJ32 memory arbiter.
//   arb_st_t  : arbiter bus-ownership state (normal core priority / host burst)
//   arb_own_t : owner tag of the access issued in a given cycle
//   sat16_inc : saturating 16-bit increment used by the optional statistics
package ej32_pkg;

   typedef enum logic {
      S_CPU = 1'b0,
      S_BST = 1'b1
   } arb_st_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_HST = 1'b1
   } arb_own_t;

   // Width of the wait/burst counters; both limits are capped at 255.
   localparam int ARB_CNT_W = 8;

   function automatic logic [15:0] sat16_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ej32_arb_cnt.sv
// ej32_arb_cnt: saturating event counter with synchronous clear and a
// "reached limit" compare. Used for the host wait counter and the burst
// beat counter of ej32_mem_arb.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear to 0 (wins over inc)
//   inc      : increment, holds at LIMIT
//   at_lim   : count equals LIMIT
module ej32_arb_cnt
   import ej32_pkg::*;
#(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic at_lim
);

   localparam logic [ARB_CNT_W-1:0] LIM = ARB_CNT_W'(LIMIT);

   logic [ARB_CNT_W-1:0] cnt;

   assign at_lim = (cnt == LIM);

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_lim) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ej32_mem_arb.sv
// ej32_mem_arb: shares the single-port byte memory between the eJ32 core and
// a host port. The core has priority; a host refused MAX_WAIT times in a row
// gets a forced one-cycle slot, and a host grant with hst_lock=1 opens a
// locked burst of up to BURST beats during which the core is stalled.
// Read data returns one cycle after the grant and is steered by a 1-bit
// owner tag.
//   core : cpu_req/cpu_we/cpu_a/cpu_wd in; cpu_stall/cpu_rvalid/cpu_rd out
//   host : hst_req/hst_we/hst_lock/hst_a/hst_wd in; hst_gnt/hst_ack/hst_rd out
//   mem  : mem_cs/mem_we/mem_a/mem_wd out (combinational); mem_rd in
// Optional: define EJ32_ARB_STATS_EN to add the st_cpu/st_hst/st_stl
// saturating grant/stall counters as output ports.
module ej32_mem_arb
   import ej32_pkg::*;
#(
   parameter int ASZ      = 17,
   parameter int MAX_WAIT = 8,
   parameter int BURST    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cpu_req,
   input  logic           cpu_we,
   input  logic [ASZ-1:0] cpu_a,
   input  logic [7:0]     cpu_wd,
   output logic           cpu_stall,
   output logic           cpu_rvalid,
   output logic [7:0]     cpu_rd,
   input  logic           hst_req,
   input  logic           hst_we,
   input  logic           hst_lock,
   input  logic [ASZ-1:0] hst_a,
   input  logic [7:0]     hst_wd,
   output logic           hst_gnt,
   output logic           hst_ack,
   output logic [7:0]     hst_rd,
   output logic           mem_cs,
   output logic           mem_we,
   output logic [ASZ-1:0] mem_a,
   output logic [7:0]     mem_wd,
   input  logic [7:0]     mem_rd
`ifdef EJ32_ARB_STATS_EN
   ,
   output logic [15:0]    st_cpu,
   output logic [15:0]    st_hst,
   output logic [15:0]    st_stl
`endif
);

   arb_st_t  st_q, st_d;
   arb_own_t own_q;
   logic     iss_q;      // an access needing a return was issued last cycle
   logic     cpu_gnt;
   logic     w_lim;      // host has been refused MAX_WAIT cycles in a row
   logic     b_lim;      // current burst is at its last allowed beat

   // Host wait counter: counts refused cycles of a pending host request.
   ej32_arb_cnt #(.LIMIT(MAX_WAIT)) u_wcnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (!hst_req || hst_gnt),
      .inc    (hst_req && !hst_gnt),
      .at_lim (w_lim)
   );

   // Burst beat counter: the entry grant takes it from 0 to 1; it is cleared
   // whenever the bus is handed back to the core.
   ej32_arb_cnt #(.LIMIT(BURST - 1)) u_bcnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (st_d == S_CPU),
      .inc    (hst_gnt),
      .at_lim (b_lim)
   );

   // Grant decision and next state. Everything is held idle while rst is
   // high so no access is issued during reset.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned and infers a latch.
      st_d      = st_q;
      hst_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      cpu_stall = 1'b0;
      if (!rst) begin
         unique case (st_q)
            S_CPU: begin
               hst_gnt   = hst_req && (!cpu_req || w_lim);
               cpu_gnt   = cpu_req && !hst_gnt;
               cpu_stall = cpu_req && hst_gnt;
               if (hst_gnt && hst_lock && (BURST > 1)) begin
                  st_d = S_BST;
               end
            end
            S_BST: begin
               hst_gnt   = hst_req;
               cpu_stall = cpu_req;
               if (!hst_lock || !hst_req || b_lim) begin
                  st_d = S_CPU;
               end
            end
            default: st_d = S_CPU;
         endcase
      end
   end

   // Memory bus follows whichever requester was granted this cycle.
   assign mem_cs = cpu_gnt || hst_gnt;
   assign mem_we = hst_gnt ? hst_we : (cpu_gnt && cpu_we);
   assign mem_a  = hst_gnt ? hst_a  : cpu_a;
   assign mem_wd = hst_gnt ? hst_wd : cpu_wd;

   // Return tagging: core writes need no return, every host access is acked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= S_CPU;
         own_q <= OWN_CPU;
         iss_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         own_q <= hst_gnt ? OWN_HST : OWN_CPU;
         iss_q <= hst_gnt || (cpu_gnt && !cpu_we);
      end
   end

   assign cpu_rvalid = iss_q && (own_q == OWN_CPU);
   assign hst_ack    = iss_q && (own_q == OWN_HST);
   assign cpu_rd     = cpu_rvalid ? mem_rd : 8'h00;
   assign hst_rd     = hst_ack    ? mem_rd : 8'h00;

`ifdef EJ32_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_cpu <= '0;
         st_hst <= '0;
         st_stl <= '0;
      end else begin
         if (cpu_gnt)   st_cpu <= sat16_inc(st_cpu);
         if (hst_gnt)   st_hst <= sat16_inc(st_hst);
         if (cpu_stall) st_stl <= sat16_inc(st_stl);
      end
   end
`endif

endmodule
